// File: rtl/tgt_engine_sched_if.sv
// Engine-scheduler bus: HDR control, CCC/DDR engine requests and muxed shared-resource outputs.
interface tgt_engine_sched_if;
    logic       i_hdr_en;
    logic       i_cmd_valid;
    logic       i_cmd_is_ccc;
    logic       i_exit_detect;
    logic       i_restart_detect;
    logic       i_tx_mode_done;
    logic       i_rx_mode_done;

    logic       i_ccc_tx_en;
    logic       i_ccc_rx_en;
    logic       i_ccc_regf_wr_en;
    logic       i_ccc_regf_rd_en;
    logic [4:0] i_ccc_tx_mode;
    logic [4:0] i_ccc_rx_mode;
    logic [7:0] i_ccc_regf_addr;
    logic       i_ccc_done;

    logic       i_ddr_tx_en;
    logic       i_ddr_rx_en;
    logic       i_ddr_regf_wr_en;
    logic       i_ddr_regf_rd_en;
    logic [4:0] i_ddr_tx_mode;
    logic [4:0] i_ddr_rx_mode;
    logic [7:0] i_ddr_regf_addr;
    logic       i_ddr_done;

    logic       o_ccc_en;
    logic       o_ddr_en;
    logic       o_tx_en;
    logic       o_rx_en;
    logic [4:0] o_tx_mode;
    logic [4:0] o_rx_mode;
    logic [7:0] o_regf_addr;
    logic       o_regf_wr_en;
    logic       o_regf_rd_en;
    logic       o_busy;
    logic       o_abort;

    modport master (
        output i_hdr_en, i_cmd_valid, i_cmd_is_ccc, i_exit_detect, i_restart_detect,
               i_tx_mode_done, i_rx_mode_done,
               i_ccc_tx_en, i_ccc_rx_en, i_ccc_regf_wr_en, i_ccc_regf_rd_en,
               i_ccc_tx_mode, i_ccc_rx_mode, i_ccc_regf_addr, i_ccc_done,
               i_ddr_tx_en, i_ddr_rx_en, i_ddr_regf_wr_en, i_ddr_regf_rd_en,
               i_ddr_tx_mode, i_ddr_rx_mode, i_ddr_regf_addr, i_ddr_done,
        input  o_ccc_en, o_ddr_en, o_tx_en, o_rx_en, o_tx_mode, o_rx_mode,
               o_regf_addr, o_regf_wr_en, o_regf_rd_en, o_busy, o_abort
    );

    modport slave (
        input  i_hdr_en, i_cmd_valid, i_cmd_is_ccc, i_exit_detect, i_restart_detect,
               i_tx_mode_done, i_rx_mode_done,
               i_ccc_tx_en, i_ccc_rx_en, i_ccc_regf_wr_en, i_ccc_regf_rd_en,
               i_ccc_tx_mode, i_ccc_rx_mode, i_ccc_regf_addr, i_ccc_done,
               i_ddr_tx_en, i_ddr_rx_en, i_ddr_regf_wr_en, i_ddr_regf_rd_en,
               i_ddr_tx_mode, i_ddr_rx_mode, i_ddr_regf_addr, i_ddr_done,
        output o_ccc_en, o_ddr_en, o_tx_en, o_rx_en, o_tx_mode, o_rx_mode,
               o_regf_addr, o_regf_wr_en, o_regf_rd_en, o_busy, o_abort
    );
endinterface

// File: rtl/tgt_engine_sched.sv
// HDR target engine scheduler: grants the shared tx/rx/regfile to the CCC or DDR engine,
// with drain, restart, exit and inactivity-timeout handling.
module tgt_engine_sched #(
    parameter logic [7:0] TIMEOUT = 8'd200
) (
    input  logic               i_sys_clk,
    input  logic               i_sys_rst,
    tgt_engine_sched_if.slave  bus
);

    localparam int unsigned CNT_W = 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARMED   = 3'd1;
    localparam logic [2:0] ST_CCC_ACT = 3'd2;
    localparam logic [2:0] ST_DDR_ACT = 3'd3;
    localparam logic [2:0] ST_DRAIN   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort_q, abort_d;
    logic             ccc_en_q, ddr_en_q, busy_q;
    logic             timeout_hit;
    logic             active_q, active_d;

    assign timeout_hit = (cnt_q >= TIMEOUT);
    assign active_q    = (state_q == ST_CCC_ACT) || (state_q == ST_DDR_ACT);
    assign active_d    = (state_d == ST_CCC_ACT) || (state_d == ST_DDR_ACT);

    // Next-state, abort pulse and inactivity counter; exit overrides everything.
    always_comb begin
        state_d = state_q;
        abort_d = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_hdr_en) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (bus.i_cmd_valid)   state_d = bus.i_cmd_is_ccc ? ST_CCC_ACT : ST_DDR_ACT;
                else if (!bus.i_hdr_en) state_d = ST_IDLE;
            end
            ST_CCC_ACT: begin
                if (bus.i_restart_detect) state_d = ST_ARMED;
                else if (bus.i_ccc_done)  state_d = ST_DRAIN;
                else if (timeout_hit) begin
                    state_d = ST_DRAIN;
                    abort_d = 1'b1;
                end
            end
            ST_DDR_ACT: begin
                if (bus.i_restart_detect) state_d = ST_ARMED;
                else if (bus.i_ddr_done)  state_d = ST_DRAIN;
                else if (timeout_hit) begin
                    state_d = ST_DRAIN;
                    abort_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d = bus.i_hdr_en ? ST_ARMED : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.i_exit_detect) begin
            state_d = ST_IDLE;
            abort_d = 1'b0;
        end

        // Counter runs only across consecutive active cycles and saturates.
        if (!active_d || !active_q || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (bus.i_tx_mode_done || bus.i_rx_mode_done) begin
            cnt_d = '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State, counter and registered status outputs.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            abort_q  <= 1'b0;
            ccc_en_q <= 1'b0;
            ddr_en_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            abort_q  <= abort_d;
            ccc_en_q <= (state_d == ST_CCC_ACT);
            ddr_en_q <= (state_d == ST_DDR_ACT);
            busy_q   <= active_d || (state_d == ST_DRAIN);
        end
    end

    // Shared-resource mux driven from the granted engine only.
    always_comb begin
        bus.o_tx_en      = 1'b0;
        bus.o_rx_en      = 1'b0;
        bus.o_tx_mode    = 5'd0;
        bus.o_rx_mode    = 5'd0;
        bus.o_regf_addr  = 8'd0;
        bus.o_regf_wr_en = 1'b0;
        bus.o_regf_rd_en = 1'b0;
        case (state_q)
            ST_CCC_ACT: begin
                bus.o_tx_en      = bus.i_ccc_tx_en;
                bus.o_rx_en      = bus.i_ccc_rx_en;
                bus.o_tx_mode    = bus.i_ccc_tx_mode;
                bus.o_rx_mode    = bus.i_ccc_rx_mode;
                bus.o_regf_addr  = bus.i_ccc_regf_addr;
                bus.o_regf_wr_en = bus.i_ccc_regf_wr_en;
                bus.o_regf_rd_en = bus.i_ccc_regf_rd_en;
            end
            ST_DDR_ACT: begin
                bus.o_tx_en      = bus.i_ddr_tx_en;
                bus.o_rx_en      = bus.i_ddr_rx_en;
                bus.o_tx_mode    = bus.i_ddr_tx_mode;
                bus.o_rx_mode    = bus.i_ddr_rx_mode;
                bus.o_regf_addr  = bus.i_ddr_regf_addr;
                bus.o_regf_wr_en = bus.i_ddr_regf_wr_en;
                bus.o_regf_rd_en = bus.i_ddr_regf_rd_en;
            end
            default: ;
        endcase
    end

    assign bus.o_ccc_en = ccc_en_q;
    assign bus.o_ddr_en = ddr_en_q;
    assign bus.o_busy   = busy_q;
    assign bus.o_abort  = abort_q;

endmodule

// File: tb/tb_tgt_engine_sched.sv
// Directed bench for the HDR engine scheduler.
module tb_tgt_engine_sched;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    tgt_engine_sched_if ifc ();

    tgt_engine_sched #(.TIMEOUT(8'd200)) dut (
        .i_sys_clk (clk),
        .i_sys_rst (rst_n),
        .bus       (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifc.i_hdr_en = 1'b0; ifc.i_cmd_valid = 1'b0; ifc.i_cmd_is_ccc = 1'b0;
        ifc.i_exit_detect = 1'b0; ifc.i_restart_detect = 1'b0;
        ifc.i_tx_mode_done = 1'b0; ifc.i_rx_mode_done = 1'b0;
        ifc.i_ccc_tx_en = 1'b0; ifc.i_ccc_rx_en = 1'b0; ifc.i_ccc_regf_wr_en = 1'b0;
        ifc.i_ccc_regf_rd_en = 1'b0; ifc.i_ccc_tx_mode = 5'd0; ifc.i_ccc_rx_mode = 5'd0;
        ifc.i_ccc_regf_addr = 8'd0; ifc.i_ccc_done = 1'b0;
        ifc.i_ddr_tx_en = 1'b0; ifc.i_ddr_rx_en = 1'b0; ifc.i_ddr_regf_wr_en = 1'b0;
        ifc.i_ddr_regf_rd_en = 1'b0; ifc.i_ddr_tx_mode = 5'd0; ifc.i_ddr_rx_mode = 5'd0;
        ifc.i_ddr_regf_addr = 8'd0; ifc.i_ddr_done = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        ifc.i_ccc_tx_en = 1'b1; ifc.i_ddr_regf_wr_en = 1'b1;
        repeat (3) tick();
        checks++; if (ifc.o_ccc_en !== 1'b0) begin errors++; $display("FAIL reset_ccc_en got %0b exp 0", ifc.o_ccc_en); end
        checks++; if (ifc.o_ddr_en !== 1'b0) begin errors++; $display("FAIL reset_ddr_en got %0b exp 0", ifc.o_ddr_en); end
        checks++; if (ifc.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", ifc.o_busy); end
        checks++; if (ifc.o_abort !== 1'b0) begin errors++; $display("FAIL reset_abort got %0b exp 0", ifc.o_abort); end
        checks++; if ({ifc.o_tx_en, ifc.o_regf_wr_en} !== 2'b00) begin errors++; $display("FAIL reset_mux got %b exp 00", {ifc.o_tx_en, ifc.o_regf_wr_en}); end
        ifc.i_ccc_tx_en = 1'b0; ifc.i_ddr_regf_wr_en = 1'b0;
        rst_n = 1'b1;
        ifc.i_hdr_en = 1'b1;
        tick();  // IDLE -> ARMED
        checks++; if (ifc.o_busy !== 1'b0) begin errors++; $display("FAIL armed_busy got %0b exp 0", ifc.o_busy); end
    endtask

    task automatic test_ccc_grant();
        ifc.i_ccc_tx_en = 1'b1; ifc.i_ccc_rx_en = 1'b0; ifc.i_ccc_regf_wr_en = 1'b0; ifc.i_ccc_regf_rd_en = 1'b1;
        ifc.i_ccc_tx_mode = 5'd0; ifc.i_ccc_rx_mode = 5'd3; ifc.i_ccc_regf_addr = 8'h02;
        ifc.i_ddr_tx_en = 1'b1; ifc.i_ddr_rx_en = 1'b1; ifc.i_ddr_regf_wr_en = 1'b1; ifc.i_ddr_regf_rd_en = 1'b1;
        ifc.i_ddr_tx_mode = 5'h1F; ifc.i_ddr_rx_mode = 5'h1F; ifc.i_ddr_regf_addr = 8'hFF;
        checks++; if (ifc.o_regf_addr !== 8'h00) begin errors++; $display("FAIL armed_mux_addr got %0h exp 0", ifc.o_regf_addr); end
        ifc.i_cmd_valid = 1'b1; ifc.i_cmd_is_ccc = 1'b1;
        tick();
        ifc.i_cmd_valid = 1'b0; ifc.i_cmd_is_ccc = 1'b0;
        checks++; if ({ifc.o_ccc_en, ifc.o_ddr_en, ifc.o_busy} !== 3'b101) begin errors++; $display("FAIL ccc_grant_en got %b exp 101", {ifc.o_ccc_en, ifc.o_ddr_en, ifc.o_busy}); end
        checks++; if ({ifc.o_tx_en, ifc.o_rx_en, ifc.o_regf_wr_en, ifc.o_regf_rd_en} !== 4'b1001) begin errors++; $display("FAIL ccc_mux_bits got %b exp 1001", {ifc.o_tx_en, ifc.o_rx_en, ifc.o_regf_wr_en, ifc.o_regf_rd_en}); end
        checks++; if ({ifc.o_tx_mode, ifc.o_rx_mode, ifc.o_regf_addr} !== {5'd0, 5'd3, 8'h02}) begin errors++; $display("FAIL ccc_mux_fields got %0h/%0h/%0h exp 0/3/2", ifc.o_tx_mode, ifc.o_rx_mode, ifc.o_regf_addr); end
        // Stray command and foreign done while CCC owns the bus.
        ifc.i_cmd_valid = 1'b1; ifc.i_cmd_is_ccc = 1'b0; ifc.i_ddr_done = 1'b1;
        tick();
        ifc.i_cmd_valid = 1'b0; ifc.i_ddr_done = 1'b0;
        checks++; if ({ifc.o_ccc_en, ifc.o_ddr_en, ifc.o_busy} !== 3'b101) begin errors++; $display("FAIL ccc_ignore_cmd got %b exp 101", {ifc.o_ccc_en, ifc.o_ddr_en, ifc.o_busy}); end
        ifc.i_ccc_done = 1'b1;
        tick();
        ifc.i_ccc_done = 1'b0;
        checks++; if ({ifc.o_ccc_en, ifc.o_busy, ifc.o_tx_en, ifc.o_regf_rd_en} !== 4'b0100) begin errors++; $display("FAIL ccc_drain got %b exp 0100", {ifc.o_ccc_en, ifc.o_busy, ifc.o_tx_en, ifc.o_regf_rd_en}); end
        // Command during DRAIN must not start DDR.
        ifc.i_cmd_valid = 1'b1; ifc.i_cmd_is_ccc = 1'b0;
        tick();
        ifc.i_cmd_valid = 1'b0;
        checks++; if ({ifc.o_ccc_en, ifc.o_ddr_en, ifc.o_busy, ifc.o_abort} !== 4'b0000) begin errors++; $display("FAIL drain_ignore_cmd got %b exp 0000", {ifc.o_ccc_en, ifc.o_ddr_en, ifc.o_busy, ifc.o_abort}); end
    endtask

    task automatic test_ddr_done();
        clear_inputs();
        ifc.i_hdr_en = 1'b1;
        ifc.i_ddr_tx_en = 1'b1; ifc.i_ddr_tx_mode = 5'h0A; ifc.i_ddr_regf_addr = 8'h5A; ifc.i_ddr_regf_wr_en = 1'b1;
        ifc.i_ccc_rx_en = 1'b1; ifc.i_ccc_regf_addr = 8'h33;
        ifc.i_cmd_valid = 1'b1; ifc.i_cmd_is_ccc = 1'b0;
        tick();
        ifc.i_cmd_valid = 1'b0;
        checks++; if ({ifc.o_ccc_en, ifc.o_ddr_en} !== 2'b01) begin errors++; $display("FAIL ddr_grant got %b exp 01", {ifc.o_ccc_en, ifc.o_ddr_en}); end
        checks++; if ({ifc.o_tx_en, ifc.o_rx_en, ifc.o_tx_mode, ifc.o_regf_addr, ifc.o_regf_wr_en} !== {1'b1, 1'b0, 5'h0A, 8'h5A, 1'b1}) begin errors++; $display("FAIL ddr_mux got %0h/%0h exp 0A/5A", ifc.o_tx_mode, ifc.o_regf_addr); end
        ifc.i_ccc_done = 1'b1;
        repeat (8) tick();
        ifc.i_ccc_done = 1'b0;
        checks++; if (ifc.o_ddr_en !== 1'b1) begin errors++; $display("FAIL ddr_ignore_ccc_done got %0b exp 1", ifc.o_ddr_en); end
        ifc.i_ddr_done = 1'b1;
        tick();
        ifc.i_ddr_done = 1'b0;
        checks++; if ({ifc.o_ddr_en, ifc.o_busy, ifc.o_tx_en, ifc.o_regf_wr_en, ifc.o_regf_addr} !== {4'b0100, 8'h00}) begin errors++; $display("FAIL ddr_drain got %b/%0h exp 0100/0", {ifc.o_ddr_en, ifc.o_busy, ifc.o_tx_en, ifc.o_regf_wr_en}, ifc.o_regf_addr); end
        tick();
        checks++; if ({ifc.o_ddr_en, ifc.o_busy} !== 2'b00) begin errors++; $display("FAIL ddr_after_drain got %b exp 00", {ifc.o_ddr_en, ifc.o_busy}); end
    endtask

    task automatic test_timeout();
        int n;
        clear_inputs();
        ifc.i_hdr_en = 1'b1;
        ifc.i_cmd_valid = 1'b1; ifc.i_cmd_is_ccc = 1'b1;
        tick();
        ifc.i_cmd_valid = 1'b0; ifc.i_cmd_is_ccc = 1'b0;
        repeat (50) tick();
        ifc.i_rx_mode_done = 1'b1;  // restarts the idle count
        tick();
        ifc.i_rx_mode_done = 1'b0;
        checks++; if ({ifc.o_ccc_en, ifc.o_abort} !== 2'b10) begin errors++; $display("FAIL timeout_mid got %b exp 10", {ifc.o_ccc_en, ifc.o_abort}); end
        n = 0;
        while (ifc.o_abort !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        checks++; if (n !== 201) begin errors++; $display("FAIL timeout_cycles got %0d exp 201", n); end
        checks++; if ({ifc.o_ccc_en, ifc.o_busy} !== 2'b01) begin errors++; $display("FAIL timeout_drain got %b exp 01", {ifc.o_ccc_en, ifc.o_busy}); end
        tick();
        checks++; if ({ifc.o_abort, ifc.o_ccc_en, ifc.o_busy} !== 3'b000) begin errors++; $display("FAIL timeout_pulse got %b exp 000", {ifc.o_abort, ifc.o_ccc_en, ifc.o_busy}); end
    endtask

    task automatic test_exit_priority();
        ifc.i_cmd_valid = 1'b1; ifc.i_cmd_is_ccc = 1'b1;
        tick();
        ifc.i_cmd_valid = 1'b0; ifc.i_cmd_is_ccc = 1'b0;
        checks++; if (ifc.o_ccc_en !== 1'b1) begin errors++; $display("FAIL exit_pre_grant got %0b exp 1", ifc.o_ccc_en); end
        ifc.i_exit_detect = 1'b1; ifc.i_restart_detect = 1'b1; ifc.i_ccc_done = 1'b1;
        tick();
        ifc.i_exit_detect = 1'b0; ifc.i_restart_detect = 1'b0; ifc.i_ccc_done = 1'b0;
        checks++; if ({ifc.o_ccc_en, ifc.o_busy, ifc.o_abort} !== 3'b000) begin errors++; $display("FAIL exit_priority got %b exp 000", {ifc.o_ccc_en, ifc.o_busy, ifc.o_abort}); end
        tick();  // IDLE -> ARMED
    endtask

    task automatic test_restart_and_hdr_drop();
        ifc.i_cmd_valid = 1'b1; ifc.i_cmd_is_ccc = 1'b0;
        tick();
        ifc.i_cmd_valid = 1'b0;
        ifc.i_restart_detect = 1'b1;
        tick();
        ifc.i_restart_detect = 1'b0;
        checks++; if ({ifc.o_ddr_en, ifc.o_busy} !== 2'b00) begin errors++; $display("FAIL restart_no_drain got %b exp 00", {ifc.o_ddr_en, ifc.o_busy}); end
        ifc.i_cmd_valid = 1'b1;
        tick();
        ifc.i_cmd_valid = 1'b0;
        checks++; if (ifc.o_ddr_en !== 1'b1) begin errors++; $display("FAIL restart_to_armed got %0b exp 1", ifc.o_ddr_en); end
        ifc.i_hdr_en = 1'b0;
        tick();
        checks++; if (ifc.o_ddr_en !== 1'b1) begin errors++; $display("FAIL hdr_drop_active got %0b exp 1", ifc.o_ddr_en); end
        ifc.i_ddr_done = 1'b1;
        tick();
        ifc.i_ddr_done = 1'b0;
        checks++; if ({ifc.o_ddr_en, ifc.o_busy} !== 2'b01) begin errors++; $display("FAIL hdr_drop_drain got %b exp 01", {ifc.o_ddr_en, ifc.o_busy}); end
        tick();  // DRAIN -> IDLE
        ifc.i_cmd_valid = 1'b1;
        tick();
        ifc.i_cmd_valid = 1'b0;
        checks++; if ({ifc.o_ccc_en, ifc.o_ddr_en, ifc.o_busy} !== 3'b000) begin errors++; $display("FAIL idle_ignore_cmd got %b exp 000", {ifc.o_ccc_en, ifc.o_ddr_en, ifc.o_busy}); end
        ifc.i_hdr_en = 1'b1;
        tick();  // IDLE -> ARMED
    endtask

    task automatic test_reset_mid();
        ifc.i_ddr_regf_wr_en = 1'b1; ifc.i_ddr_regf_addr = 8'h44;
        ifc.i_cmd_valid = 1'b1; ifc.i_cmd_is_ccc = 1'b0;
        tick();
        ifc.i_cmd_valid = 1'b0;
        checks++; if (ifc.o_regf_wr_en !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got %0b exp 1", ifc.o_regf_wr_en); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({ifc.o_regf_wr_en, ifc.o_ddr_en, ifc.o_busy} !== 3'b000) begin errors++; $display("FAIL rst_mid_async got %b exp 000", {ifc.o_regf_wr_en, ifc.o_ddr_en, ifc.o_busy}); end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();  // IDLE -> ARMED
        tick();
        checks++; if ({ifc.o_ddr_en, ifc.o_busy, ifc.o_regf_wr_en} !== 3'b000) begin errors++; $display("FAIL rst_mid_needs_cmd got %b exp 000", {ifc.o_ddr_en, ifc.o_busy, ifc.o_regf_wr_en}); end
        ifc.i_cmd_valid = 1'b1;
        tick();
        ifc.i_cmd_valid = 1'b0;
        checks++; if ({ifc.o_ddr_en, ifc.o_regf_addr} !== {1'b1, 8'h44}) begin errors++; $display("FAIL rst_mid_new_cmd got %0b/%0h exp 1/44", ifc.o_ddr_en, ifc.o_regf_addr); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_ccc_grant();
        test_ddr_done();
        test_timeout();
        test_exit_priority();
        test_restart_and_hdr_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
